// File: rtl/seven_seg_pkg.sv
// Shared digit-code encoding for the seven-segment scan path and its decoder.
package seven_seg_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned BLANK_BIT = 6;
  localparam int unsigned DP_BIT    = 5;
  localparam int unsigned DASH_BIT  = 4;

  typedef logic [SEG_W-1:0] seg_code_t;

  localparam seg_code_t CODE_BLANK = 7'b1000000;
  localparam seg_code_t CODE_DASH  = 7'b0010000;
  localparam seg_code_t CODE_ZERO  = 7'b0000000;

  // A plain zero digit: no blank/dp/dash flag and a zero value nibble.
  function automatic logic is_zero(input seg_code_t code);
    return !code[BLANK_BIT] && !code[DP_BIT] && !code[DASH_BIT]
           && (code[3:0] == CODE_ZERO[3:0]);
  endfunction

  // True when a code lights only the middle segment.
  function automatic logic is_dash(input seg_code_t code);
    return code == CODE_DASH;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Modulo-CLK_DIV prescaler; step_c is high for the one cycle the count sits at CLK_DIV-1.
module tick_div #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic step_c
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] CNT_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign step_c = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (step_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexes NDIG shadowed digit codes onto one decoder input with active-low anodes.
// Shadow writes reach the displayed set only at a frame boundary after a commit request.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned NDIG    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [6:0]              wr_data,
  input  logic                    commit,
  input  logic                    lzs_en,
  input  logic                    blank_all,
  output logic [6:0]              d_out,
  output logic [NDIG-1:0]         an_n,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic            step_c;
  logic            frame_step;
  logic            apply_commit;
  logic            pending_nxt;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_nxt;
  logic [NDIG-1:0] an_nxt;
  seg_code_t       shadow_q   [NDIG];
  seg_code_t       shadow_nxt [NDIG];
  seg_code_t       active_q   [NDIG];
  seg_code_t       active_nxt [NDIG];
  seg_code_t       disp_c     [NDIG];

  tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .step_c (step_c)
  );

  // Digit index advance; the step out of the last digit is the frame boundary.
  always_comb begin
    frame_step = step_c && (idx_q == IDX_LAST);
    idx_nxt    = idx_q;
    if (step_c) begin
      idx_nxt = frame_step ? '0 : idx_q + IW'(1);
    end
  end

  // Shadow write and atomic shadow-to-active copy; a same-cycle write is included.
  always_comb begin
    apply_commit = frame_step && (pending || commit);
    pending_nxt  = apply_commit ? 1'b0 : (pending || commit);
    for (int i = 0; i < NDIG; i++) begin
      shadow_nxt[i] = shadow_q[i];
      if (wr_en && (32'(wr_addr) == 32'(i))) begin
        shadow_nxt[i] = seg_code_t'(wr_data);
      end
      active_nxt[i] = apply_commit ? shadow_nxt[i] : active_q[i];
    end
  end

  // Leading-zero suppression scans from the top digit down; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_run  = zero_run && is_zero(active_nxt[k]);
      disp_c[k] = (lzs_en && zero_run && (k != 0)) ? CODE_BLANK : active_nxt[k];
    end
  end

  always_comb begin
    an_nxt = '1;
    if (!blank_all) begin
      an_nxt = ~(NDIG'(1) << idx_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      pending    <= 1'b0;
      d_out      <= CODE_BLANK;
      an_n       <= '1;
      frame_tick <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= CODE_BLANK;
        active_q[i] <= CODE_BLANK;
      end
    end else begin
      idx_q      <= idx_nxt;
      pending    <= pending_nxt;
      d_out      <= disp_c[idx_nxt];
      an_n       <= an_nxt;
      frame_tick <= frame_step;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= shadow_nxt[i];
        active_q[i] <= active_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with CLK_DIV=4, NDIG=8 (32-cycle frame).
module tb_seven_seg_scan;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NDIG    = 8;
  localparam int          FRAME   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       lzs_en = 1'b0;
  logic       blank_all = 1'b0;
  logic [6:0] d_out;
  logic [7:0] an_n;
  logic       frame_tick;
  logic       pending;

  int n_edges  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan #(
    .CLK_DIV (CLK_DIV),
    .NDIG    (NDIG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .lzs_en     (lzs_en),
    .blank_all  (blank_all),
    .d_out      (d_out),
    .an_n       (an_n),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Edges since reset release: phase within frame = n_edges % FRAME, digit = phase / CLK_DIV.
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; commit = 1'b0; lzs_en = 1'b0; blank_all = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((n_edges % FRAME) != ph) && (k < 2 * FRAME));
    if ((n_edges % FRAME) != ph) begin
      n_checks++; n_fail++;
      $display("FAIL wait_phase: reached phase %0d, required %0d", n_edges % FRAME, ph);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    logic       exp_ft;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (an_n !== 8'hFF) begin n_fail++; $display("FAIL reset_an_n: got %h, expected ff", an_n); end
    n_checks++; if (d_out !== 7'h40) begin n_fail++; $display("FAIL reset_d_out: got %h, expected 40", d_out); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b, expected 0", pending); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: got %b, expected 0", frame_tick); end
    rst = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      exp_an = ~(8'(1) << ((i / 4) % 8));
      exp_ft = ((i % FRAME) == 0);
      n_checks++;
      if (an_n !== exp_an) begin
        n_fail++; $display("FAIL scan_an_n cycle %0d: got %h, expected %h", i, an_n, exp_an);
      end
      n_checks++;
      if (frame_tick !== exp_ft) begin
        n_fail++; $display("FAIL scan_frame_tick cycle %0d: got %b, expected %b", i, frame_tick, exp_ft);
      end
      n_checks++;
      if (d_out !== 7'h40) begin
        n_fail++; $display("FAIL scan_d_out cycle %0d: got %h, expected 40", i, d_out);
      end
    end
  endtask

  task automatic test_deferred_commit();
    do_reset();
    for (int p = 0; p < 8; p++) begin
      wr_en = 1'b1; wr_addr = 3'(p); wr_data = 7'(p + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL defer_pending_set: got %b, expected 1", pending); end
    n_checks++; if (d_out !== 7'h40) begin n_fail++; $display("FAIL defer_d_out_early: got %h, expected 40", d_out); end
    wait_phase(31);
    n_checks++; if (d_out !== 7'h40) begin n_fail++; $display("FAIL defer_d_out_last: got %h, expected 40", d_out); end
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL defer_pending_hold: got %b, expected 1", pending); end
    wait_phase(0);
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL defer_pending_clear: got %b, expected 0", pending); end
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL defer_frame_tick: got %b, expected 1", frame_tick); end
    n_checks++; if (an_n !== 8'hFE) begin n_fail++; $display("FAIL defer_an_n: got %h, expected fe", an_n); end
    n_checks++; if (d_out !== 7'h01) begin n_fail++; $display("FAIL defer_pos0: got %h, expected 01", d_out); end
    for (int k = 1; k < 8; k++) begin
      wait_phase(4 * k);
      n_checks++;
      if (d_out !== 7'(k + 1)) begin
        n_fail++; $display("FAIL defer_pos%0d: got %h, expected %h", k, d_out, 7'(k + 1));
      end
    end
  endtask

  task automatic test_boundary_race();
    wait_phase(31);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 7'h05; commit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL race_pending: got %b, expected 0", pending); end
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL race_frame_tick: got %b, expected 1", frame_tick); end
    wait_phase(8);
    n_checks++; if (d_out !== 7'h03) begin n_fail++; $display("FAIL race_pos2: got %h, expected 03", d_out); end
    wait_phase(12);
    n_checks++; if (d_out !== 7'h05) begin n_fail++; $display("FAIL race_pos3: got %h, expected 05", d_out); end
    // Boundary write without a pending commit must stay in shadow.
    wait_phase(31);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 7'h0A;
    @(negedge clk);
    wr_en = 1'b0;
    wait_phase(16);
    n_checks++; if (d_out !== 7'h05) begin n_fail++; $display("FAIL shadow_only_pos4: got %h, expected 05", d_out); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL shadow_only_pending: got %b, expected 0", pending); end
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL late_commit_pending: got %b, expected 1", pending); end
    wait_phase(16);
    n_checks++; if (d_out !== 7'h0A) begin n_fail++; $display("FAIL late_commit_pos4: got %h, expected 0a", d_out); end
  endtask

  task automatic test_lzs();
    logic [6:0] wr_tab [8];
    logic [6:0] exp_a  [8];
    logic [6:0] exp_b  [8];
    wr_tab[0] = 7'h07; wr_tab[1] = 7'h00; wr_tab[2] = 7'h01; wr_tab[3] = 7'h00;
    wr_tab[4] = 7'h00; wr_tab[5] = 7'h00; wr_tab[6] = 7'h00; wr_tab[7] = 7'h00;
    exp_a[0] = 7'h07; exp_a[1] = 7'h00; exp_a[2] = 7'h01; exp_a[3] = 7'h40;
    exp_a[4] = 7'h40; exp_a[5] = 7'h40; exp_a[6] = 7'h40; exp_a[7] = 7'h40;
    exp_b[0] = 7'h07; exp_b[1] = 7'h00; exp_b[2] = 7'h01; exp_b[3] = 7'h00;
    exp_b[4] = 7'h20; exp_b[5] = 7'h40; exp_b[6] = 7'h40; exp_b[7] = 7'h40;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      wr_en = 1'b1; wr_addr = 3'(p); wr_data = wr_tab[p];
      @(negedge clk);
    end
    wr_en = 1'b0; lzs_en = 1'b1; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    wait_phase(0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) wait_phase(4 * k);
      n_checks++;
      if (d_out !== exp_a[k]) begin
        n_fail++; $display("FAIL lzs_pos%0d: got %h, expected %h", k, d_out, exp_a[k]);
      end
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 7'h20; commit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    wait_phase(0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) wait_phase(4 * k);
      n_checks++;
      if (d_out !== exp_b[k]) begin
        n_fail++; $display("FAIL lzs_dp_pos%0d: got %h, expected %h", k, d_out, exp_b[k]);
      end
    end
    lzs_en = 1'b0;
    wait_phase(28);
    n_checks++; if (d_out !== 7'h00) begin n_fail++; $display("FAIL lzs_off_pos7: got %h, expected 00", d_out); end
    lzs_en = 1'b1;
  endtask

  task automatic test_blank_all();
    logic exp_ft;
    wait_phase(0);
    blank_all = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      exp_ft = (i == FRAME);
      n_checks++;
      if (an_n !== 8'hFF) begin
        n_fail++; $display("FAIL blank_an_n phase %0d: got %h, expected ff", i, an_n);
      end
      n_checks++;
      if (frame_tick !== exp_ft) begin
        n_fail++; $display("FAIL blank_frame_tick phase %0d: got %b, expected %b", i, frame_tick, exp_ft);
      end
      if (i == 8) begin
        n_checks++;
        if (d_out !== 7'h01) begin n_fail++; $display("FAIL blank_d_out_pos2: got %h, expected 01", d_out); end
      end
    end
    blank_all = 1'b0;
    @(negedge clk);
    n_checks++; if (an_n !== 8'hFE) begin n_fail++; $display("FAIL unblank_pos0: got %h, expected fe", an_n); end
    n_checks++; if (d_out !== 7'h07) begin n_fail++; $display("FAIL unblank_d_out: got %h, expected 07", d_out); end
    wait_phase(4);
    n_checks++; if (an_n !== 8'hFD) begin n_fail++; $display("FAIL unblank_pos1: got %h, expected fd", an_n); end
  endtask

  task automatic test_mid_reset();
    lzs_en = 1'b0;
    wait_phase(1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'h09; commit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    wait_phase(20);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL midrst_pending_before: got %b, expected 1", pending); end
    n_checks++; if (an_n !== 8'hDF) begin n_fail++; $display("FAIL midrst_an_n_before: got %h, expected df", an_n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: got %b, expected 0", pending); end
    n_checks++; if (an_n !== 8'hFF) begin n_fail++; $display("FAIL midrst_an_n: got %h, expected ff", an_n); end
    n_checks++; if (d_out !== 7'h40) begin n_fail++; $display("FAIL midrst_d_out: got %h, expected 40", d_out); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_tick: got %b, expected 0", frame_tick); end
    commit = 1'b1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      commit = 1'b0;
      n_checks++;
      if (d_out !== 7'h40) begin
        n_fail++; $display("FAIL midrst_stale_d_out cycle %0d: got %h, expected 40", i, d_out);
      end
      if (i == 1 || i == FRAME) begin
        n_checks++;
        if (pending !== (i == 1)) begin
          n_fail++; $display("FAIL midrst_commit_pending cycle %0d: got %b, expected %b", i, pending, (i == 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_deferred_commit();
    test_boundary_race();
    test_lzs();
    test_blank_all();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
